core_mul_unit: RTL

Multicycle integer multiplier execution unit. It is the receiving end of the dispatch stage's single-issue port: it consumes start_mul, dec_single, single_rd_value_a and single_rd_value_b. It computes the low 32 bits of ra*rb iteratively and returns the result through a valid/ready writeback port. It exports busy and a pending-destination mask so the dispatch hazard logic can stall structural and RAW conflicts.

---
 rtl/core_mul_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/core_mul_unit.sv
// core_mul_unit: iterative 32x32->32 integer multiplier sitting on the
// dispatch single-issue port. Retires STEP_BITS multiplier bits per cycle
// and hands the low product word back through a valid/ready writeback port.

package core_mul_pkg;
  typedef logic [31:0] word;
  typedef logic [15:0] hword;
  typedef logic [3:0]  reg_num;

  typedef struct packed {
    reg_num      rd;
    reg_num      rs1;
    reg_num      rs2;
    logic [19:0] imm;
  } insn_data_t;

  typedef struct packed {
    logic [6:0] opcode;
    insn_data_t data;
  } insn_decode;
endpackage

module core_mul_unit
  import core_mul_pkg::*;
#(
  parameter int STEP_BITS = 2  // legal: 1, 2, 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  insn_decode dec,
  input  word        op_a,
  input  word        op_b,
  input  logic       wb_ready,
  output logic       busy,
  output hword       pending_mask,
  output logic       wb_valid,
  output reg_num     wb_rd,
  output word        wb_value
);

  localparam int N  = 32 / STEP_BITS;
  localparam int CW = $clog2(N);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  word           acc_q, acc_d;
  word           mcand_q, mcand_d;
  word           mplier_q, mplier_d;
  reg_num        rd_q, rd_d;
  word           pp;

  // Only dec.data.rd matters here; fold the rest into a sink net.
  logic unused_dec;
  assign unused_dec = ^{dec.opcode, dec.data.rs1, dec.data.rs2, dec.data.imm};

  // Partial product of the multiplicand and the low STEP_BITS multiplier bits.
  // The multiplicand register is pre-shifted each step, so no per-iteration
  // shift is needed here.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pp = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
  end

  // Next-state and datapath update for the IDLE -> RUN -> WB sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rd_d     = rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          cnt_d    = CW'(N - 1);
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          rd_d     = dec.data.rd;
        end
      end
      ST_RUN: begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << STEP_BITS;
        mplier_d = mplier_q >> STEP_BITS;
        if (cnt_q == '0) state_d = ST_WB;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_WB: begin
        // Result held until accepted; a start seen here is ignored.
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers: only meaningful while busy.
  always_ff @(posedge clk) begin
    // NOTE: no reset here on purpose; these values are qualified by the
    // control state and are always loaded before they are observed.
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    rd_q     <= rd_d;
  end

  assign busy         = (state_q != ST_IDLE);
  assign wb_valid     = (state_q == ST_WB);
  assign pending_mask = busy ? (hword'(1) << rd_q) : '0;
  assign wb_rd        = rd_q;
  assign wb_value     = acc_q;

  // Dispatch must stall on busy; a start here is a protocol violation.
  a_no_start_while_busy : assert property (
    @(posedge clk) disable iff (!rst_n) !(start && busy)
  ) else $warning("core_mul_unit: start while busy ignored");

endmodule
